// File: rtl/scan_pkg.sv
// Shared constants and index type for the 2-D block scan logic.
package scan_pkg;

   localparam int DEF_BLOCK_SIZE = 8;
   localparam int DEF_IDX_WIDTH  = $clog2(DEF_BLOCK_SIZE);
   localparam int LAST_IDX       = DEF_BLOCK_SIZE - 1;

   typedef logic [DEF_IDX_WIDTH-1:0] idx_t;

endpackage : scan_pkg

// File: rtl/block_scan_counter_ff_en.sv
// Generic WIDTH-bit enable register with asynchronous reset to a supplied value.
module ff_en #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] rst_val,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         Q <= rst_val;
      else if (en)
         Q <= D;
   end

endmodule : ff_en

// File: rtl/block_scan_counter.sv
// Row-major (u, v) index generator over a BLOCK_SIZE x BLOCK_SIZE block.
// Define SCAN_WRAP_EN to wrap from the terminal position to (0,0) instead of saturating.
module block_scan_counter
   import scan_pkg::*;
#(
   parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
   parameter int IDX_WIDTH  = $clog2(BLOCK_SIZE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 restart,
   input  logic                 go,
   output logic [IDX_WIDTH-1:0] u,
   output logic [IDX_WIDTH-1:0] v,
   output logic                 done
);

   localparam logic [IDX_WIDTH-1:0] LAST_POS = IDX_WIDTH'(BLOCK_SIZE - 1);
   localparam logic [IDX_WIDTH-1:0] ZERO     = '0;
   localparam logic [IDX_WIDTH-1:0] ONE      = IDX_WIDTH'(1);

   logic                 at_last;
   logic                 en;
   logic [IDX_WIDTH-1:0] u_next;
   logic [IDX_WIDTH-1:0] v_next;

   assign at_last = (u == LAST_POS) && (v == LAST_POS);
   assign en      = restart | go;
   assign done    = at_last && go && !restart;

   // Next-state values only matter when en is high; with en low both registers hold.
   always_comb begin
      u_next = u;
      v_next = v;
      if (restart) begin
         u_next = ZERO;
         v_next = ZERO;
      end else if (at_last) begin
`ifdef SCAN_WRAP_EN
         u_next = ZERO;
         v_next = ZERO;
`else
         u_next = u;
         v_next = v;
`endif
      end else if (v == LAST_POS) begin
         u_next = u + ONE;
         v_next = ZERO;
      end else begin
         v_next = v + ONE;
      end
   end

   ff_en #(.WIDTH(IDX_WIDTH)) u_reg (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .rst_val (ZERO),
      .D       (u_next),
      .Q       (u)
   );

   ff_en #(.WIDTH(IDX_WIDTH)) v_reg (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .rst_val (ZERO),
      .D       (v_next),
      .Q       (v)
   );

endmodule : block_scan_counter

// File: tb/tb_block_scan_counter.sv
// Directed bench for block_scan_counter and the standalone ff_en register.
module tb_block_scan_counter;
   import scan_pkg::*;

   logic       clk;
   logic       rst;
   logic       restart;
   logic       go;
   idx_t       u;
   idx_t       v;
   logic       done;

   logic       f_rst;
   logic       f_en;
   logic [7:0] f_rst_val;
   logic [7:0] f_d;
   logic [7:0] f_q;

   int checks = 0;
   int errors = 0;

   block_scan_counter dut (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .go      (go),
      .u       (u),
      .v       (v),
      .done    (done)
   );

   ff_en #(.WIDTH(8)) ff_dut (
      .clk     (clk),
      .rst     (f_rst),
      .en      (f_en),
      .rst_val (f_rst_val),
      .D       (f_d),
      .Q       (f_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_pos(input string tag, input int eu, input int ev, input logic edone);
      check({tag, "_u"}, 32'(u), 32'(eu));
      check({tag, "_v"}, 32'(v), 32'(ev));
      check({tag, "_done"}, 32'(done), 32'(edone));
   endtask

   // Restart for one cycle, then advance n positions with go held high.
   task automatic go_to(input int n);
      restart = 1'b1;
      go      = 1'b0;
      tick();
      restart = 1'b0;
      go      = 1'b1;
      repeat (n) tick();
   endtask

   initial begin
      rst       = 1'b1;
      restart   = 1'b0;
      go        = 1'b0;
      f_rst     = 1'b1;
      f_en      = 1'b0;
      f_rst_val = 8'hA5;
      f_d       = 8'h00;
      #1;
      check_pos("reset_init", 0, 0, 1'b0);
      check("ff_rst", 32'(f_q), 32'h0000_00A5);
      tick();
      rst   = 1'b0;
      f_rst = 1'b0;

      // ff_en standalone: hold with en low, load with en high
      f_en = 1'b0;
      f_d  = 8'h3C;
      tick();
      check("ff_hold", 32'(f_q), 32'h0000_00A5);
      f_en = 1'b1;
      tick();
      check("ff_load", 32'(f_q), 32'h0000_003C);

      // full scan: position k presented in cycle k, done only at k=63
      go_to(0);
      for (int k = 0; k < 64; k++) begin
         check_pos($sformatf("scan%0d", k), k / 8, k % 8, (k == 63));
         tick();
      end

      // terminal behaviour for three cycles beyond the last position
`ifdef SCAN_WRAP_EN
      check_pos("term0", 0, 0, 1'b0);
      tick();
      check_pos("term1", 0, 1, 1'b0);
      tick();
      check_pos("term2", 0, 2, 1'b0);
`else
      for (int k = 0; k < 3; k++) begin
         check_pos($sformatf("term%0d", k), 7, 7, 1'b1);
         tick();
      end
      restart = 1'b1;
      #1;
      check("term_restart_done", 32'(done), 32'(0));
      tick();
      restart = 1'b0;
      check_pos("term_restart", 0, 0, 1'b1 && (u == 3'd7));
`endif

      // stall at (2,6)
      go_to(22);
      check_pos("stall_at", 2, 6, 1'b0);
      go = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check_pos($sformatf("stall%0d", k), 2, 6, 1'b0);
      end
      go = 1'b1;
      tick();
      check_pos("resume0", 2, 7, 1'b0);
      tick();
      check_pos("resume1", 3, 0, 1'b0);

      // restart and go together at (4,4)
      go_to(36);
      check_pos("prio_at", 4, 4, 1'b0);
      restart = 1'b1;
      go      = 1'b1;
      #1;
      check("prio_done", 32'(done), 32'(0));
      tick();
      restart = 1'b0;
      check_pos("prio_next", 0, 0, 1'b0);
      tick();
      check_pos("prio_run", 0, 1, 1'b0);

      // asynchronous reset mid-scan at (3,5)
      go_to(29);
      check_pos("rst_at", 3, 5, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_pos("rst_async", 0, 0, 1'b0);
      tick();
      check_pos("rst_held", 0, 0, 1'b0);
      rst = 1'b0;
      tick();
      check_pos("rst_resume0", 0, 1, 1'b0);
      tick();
      check_pos("rst_resume1", 0, 2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_block_scan_counter

// File: doc/block_scan_counter.md
Name: block_scan_counter

Overview:
- Two-dimensional index generator that walks every (u, v) position of a BLOCK_SIZE x BLOCK_SIZE block, one position per enabled cycle.
- Drives the row/column selects and the terminal flag used by the 2-D transform engines.
- The IDCT FSM holds it in restart while idle and asserts go while calculating. done moves that FSM to its DONE state.
- All state is held in instances of the shared enable flip-flop, ff_en.

Parameters:
- BLOCK_SIZE, 8: block edge length; must be a power of two and at least 2.
- IDX_WIDTH, $clog2(BLOCK_SIZE) (3 at default): width of the u and v indices.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- restart  input  1  synchronous return to (0,0); takes priority over go.
- go  input  1  advance enable.
- u  output  IDX_WIDTH  outer (row) index; registered.
- v  output  IDX_WIDTH  inner (column) index; registered.
- done  output  1  terminal-position flag; combinational from the registered state.

Behaviour:
- Reset: while rst=1, u=0 and v=0 immediately, without waiting for a clock edge; done=0.
- Scan order is row-major: v is the inner index and u the outer index.
- Priority each rising edge:
  - restart=1: u<=0, v<=0, regardless of go.
  - else go=1 and not at terminal: if v<BLOCK_SIZE-1 then v<=v+1; else v<=0 and u<=u+1.
  - else go=1 and at terminal (u=v=BLOCK_SIZE-1): hold (saturate).
  - else (go=0): hold.
- done = (u==BLOCK_SIZE-1) && (v==BLOCK_SIZE-1) && go && !restart. It is combinational, with no extra latency.
- Latency: after restart is released with go held high, position k (0..63) is presented in cycle k. done is high in cycle 63, the same cycle that the last element is captured.
- go is held high with no restart: done stays high every cycle at the terminal position.
- go deasserted mid-scan: the indices freeze and resume when go returns. done is low while go=0.
- rst asserted mid-scan: the indices clear asynchronously. Scanning resumes from (0,0) after rst falls, if go=1.
- restart and go both high: restart wins; the indices read (0,0) in the next cycle.
- ff_en sub-module behaviour:
  - Ports: clk, rst, en, rst_val[WIDTH], D[WIDTH], Q[WIDTH].
  - Q is loaded with rst_val asynchronously while rst=1.
  - Otherwise Q<=D on a rising edge when en=1, and holds when en=0.
- The counter instantiates one ff_en for u and one for v, each with rst_val=0 and en=restart|go.

Optional Feature:
- Macro: SCAN_WRAP_EN.
- Defined: at the terminal position with go=1 and restart=0, the next edge wraps the counter to (0,0) instead of saturating. done pulses for exactly one cycle per 64-position pass, and continuous scanning needs no restart.
- Undefined: the counter saturates at the terminal position as specified above.

Decomposition:
- Shared package scan_pkg holds:
  - the BLOCK_SIZE default (8);
  - the derived IDX_WIDTH;
  - the typedef idx_t (logic [IDX_WIDTH-1:0]);
  - the constant LAST_IDX = BLOCK_SIZE-1.
- One natural sub-module: ff_en, the generic WIDTH-bit enable register with asynchronous reset to rst_val. It is reused by the FSM state registers and the coefficient registers elsewhere in the codebase.

Test Plan:
- Reset: assert rst mid-scan at (3,5) -> u=0, v=0 before the next clock edge; done=0 while rst is high.
- Full scan: restart for 1 cycle, then go=1 for 64 cycles -> the sequence (0,0),(0,1)..(0,7),(1,0)..(7,7); done=1 only in cycle 63 at (7,7).
- Stall: go=0 for 5 cycles at (2,6) -> indices hold at (2,6); scanning resumes at (2,7) then (3,0).
- Priority: restart=1 and go=1 at (4,4) -> next cycle (0,0), done=0.
- Terminal: go=1 held for 3 cycles past (7,7) -> without SCAN_WRAP_EN, stays at (7,7) with done=1 each cycle; with SCAN_WRAP_EN, goes to (0,0),(0,1) and done is high for 1 cycle.
- ff_en standalone: rst_val=8'hA5 -> Q=A5 during rst; en=0 with D=3C -> Q stays A5; en=1 -> Q=3C on the next edge.
